// File: rtl/pipeline_flow_ctrl_if.sv
// Pixel handshake bundle between the source/sink side and the pipeline flow controller.
interface pipeline_flow_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_last;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Frame sequencer and stage-enable generator for an enable-gated pixel pipeline.
// Optional backpressure stall counter is built only when PIPE_STATS_EN is defined.
module pipeline_flow_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 frame_start_i,
    input  logic [CNT_W-1:0]     frame_len_i,
    input  logic                 abort_i,
    pipeline_flow_ctrl_if.slave  pix,
    output logic [STAGES-1:0]    stage_en_o,
    output logic [STAGES-1:0]    stage_valid_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [CNT_W-1:0]     stall_cycles_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [STAGES-1:0]  valid_q, valid_d;
    logic [STAGES-1:0]  last_q, last_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [STAGES-1:0]  rdy;
    logic               ready_chain;
    logic               acc;
    logic               acc_last;

    // A stage may load when it is empty or the stage downstream is loading too.
    always_comb begin
        ready_chain = pix.out_ready;
        rdy         = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready_chain = !valid_q[i] | ready_chain;
            rdy[i]      = ready_chain;
        end
    end

    assign pix.in_ready  = rdy[0] & (state_q == RUN);
    assign acc           = pix.in_valid & pix.in_ready;
    assign acc_last      = acc & (remaining_q == CNT_W'(1));
    assign pix.out_valid = valid_q[STAGES-1];
    assign pix.out_last  = valid_q[STAGES-1] & last_q[STAGES-1];
    assign stage_en_o    = rdy;
    assign stage_valid_o = valid_q;
    assign busy_o        = (state_q != IDLE);
    assign frame_done_o  = (state_q == DONE);

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (rdy[0]) begin
            valid_d[0] = acc;
            last_d[0]  = acc_last;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                last_d[i]  = last_q[i-1];
            end
        end
        if (abort_i) begin
            valid_d = '0;
            last_d  = '0;
        end
    end

    // An empty frame skips RUN/DRAIN so frame_done still pulses exactly once.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    remaining_d = frame_len_i;
                    state_d     = (frame_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pix.out_valid & pix.out_ready & pix.out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_i) begin
            state_d     = IDLE;
            remaining_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            last_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             start_acc;

    assign start_acc = frame_start_i & (state_q == IDLE);

    // Saturating count of cycles where the sink holds off a valid output.
    always_comb begin
        stall_d = stall_q;
        if (abort_i | start_acc) begin
            stall_d = '0;
        end else if (pix.out_valid & !pix.out_ready & (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed self-checking bench for pipeline_flow_ctrl with a 4-stage enable-gated data shadow.
module tb_pipeline_flow_ctrl;

    localparam int STAGES = 4;
    localparam int CNT_W  = 16;

`ifdef PIPE_STATS_EN
    localparam logic [31:0] STALL_T3 = 32'd4;
    localparam logic [31:0] STALL_T6 = 32'd5;
`else
    localparam logic [31:0] STALL_T3 = 32'd0;
    localparam logic [31:0] STALL_T6 = 32'd0;
`endif

    localparam logic [3:0] EXPV2 [14] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF,
                                          4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    localparam logic [3:0] EXPV3 [17] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                          4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    localparam logic       EXPR3 [17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [3:0] EXPV4 [21] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5,
                                          4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h0};

    logic              clk = 1'b0;
    logic              reset;
    logic              frameStart;
    logic [CNT_W-1:0]  frameLen;
    logic              abortIn;
    logic [STAGES-1:0] stageEn;
    logic [STAGES-1:0] stageValid;
    logic              busy;
    logic              frameDone;
    logic [CNT_W-1:0]  stallCycles;

    int nChecks = 0;
    int nFail   = 0;
    int outIdx  = 0;
    int srcData, srcNext;
    int pipeData [STAGES];
    int nextData [STAGES];

    pipeline_flow_ctrl_if pix();

    pipeline_flow_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .frame_start_i  (frameStart),
        .frame_len_i    (frameLen),
        .abort_i        (abortIn),
        .pix            (pix.slave),
        .stage_en_o     (stageEn),
        .stage_valid_o  (stageValid),
        .busy_o         (busy),
        .frame_done_o   (frameDone),
        .stall_cycles_o (stallCycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic [CNT_W-1:0] len, input logic ab,
                                 input logic iv, input logic ordy);
        @(posedge clk);
        #1;
        frameStart    = fs;
        frameLen      = len;
        abortIn       = ab;
        pix.in_valid  = iv;
        pix.out_ready = ordy;
        #1;
    endtask

    // Shadow data pipeline clocked by the DUT enables: checks order, loss and duplication.
    always @(negedge clk) begin
        if (pix.out_valid && pix.out_ready) begin
            checkOutput($sformatf("data_out%0d", outIdx), pipeData[STAGES-1], outIdx);
            outIdx++;
        end
        if (frameStart) begin
            outIdx  = 0;
            srcNext = 0;
        end else if (pix.in_valid && pix.in_ready) begin
            srcNext = srcData + 1;
        end else begin
            srcNext = srcData;
        end
        nextData[0] = stageEn[0] ? srcData : pipeData[0];
        for (int i = 1; i < STAGES; i++) begin
            nextData[i] = stageEn[i] ? pipeData[i-1] : pipeData[i];
        end
    end

    always @(posedge clk) begin
        srcData  <= srcNext;
        pipeData <= nextData;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic gotDone;

        reset         = 1'b1;
        frameStart    = 1'b0;
        frameLen      = '0;
        abortIn       = 1'b0;
        pix.in_valid  = 1'b1;
        pix.out_ready = 1'b1;

        // Reset values
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_valid", 32'(stageValid), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_in_ready", 32'(pix.in_ready), 32'h0);
        checkOutput("rst_done", 32'(frameDone), 32'h0);
        checkOutput("rst_out_valid", 32'(pix.out_valid), 32'h0);
        checkOutput("rst_stall", 32'(stallCycles), 32'h0);
        reset = 1'b0;

        // Basic frame of 8, free flowing
        applyStimulus(1'b1, 16'd8, 1'b0, 1'b1, 1'b1);
        checkOutput("t2_idle_in_ready", 32'(pix.in_ready), 32'h0);
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("t2_valid_k%0d", k), 32'(stageValid), 32'(EXPV2[k-1]));
            checkOutput($sformatf("t2_in_ready_k%0d", k), 32'(pix.in_ready), 32'(k <= 8));
            checkOutput($sformatf("t2_last_k%0d", k), 32'(pix.out_last), 32'(k == 12));
            checkOutput($sformatf("t2_done_k%0d", k), 32'(frameDone), 32'(k == 13));
            checkOutput($sformatf("t2_busy_k%0d", k), 32'(busy), 32'(k <= 13));
        end
        checkOutput("t2_out_count", 32'(outIdx), 32'd8);

        // Backpressure on cycles 6-9
        applyStimulus(1'b1, 16'd8, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, !(k >= 6 && k <= 9));
            checkOutput($sformatf("t3_valid_k%0d", k), 32'(stageValid), 32'(EXPV3[k-1]));
            checkOutput($sformatf("t3_in_ready_k%0d", k), 32'(pix.in_ready), 32'(EXPR3[k-1]));
            checkOutput($sformatf("t3_done_k%0d", k), 32'(frameDone), 32'(k == 17));
        end
        checkOutput("t3_out_count", 32'(outIdx), 32'd8);
        checkOutput("t3_stall", 32'(stallCycles), STALL_T3);

        // Input bubbles every other cycle
        applyStimulus(1'b1, 16'd8, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 21; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, (k % 2 == 1) && (k <= 15), 1'b1);
            checkOutput($sformatf("t4_valid_k%0d", k), 32'(stageValid), 32'(EXPV4[k-1]));
            checkOutput($sformatf("t4_last_k%0d", k), 32'(pix.out_last), 32'(k == 19));
            checkOutput($sformatf("t4_done_k%0d", k), 32'(frameDone), 32'(k == 20));
        end
        checkOutput("t4_out_count", 32'(outIdx), 32'd8);

        // Empty frame
        applyStimulus(1'b1, 16'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_busy_k1", 32'(busy), 32'h1);
        checkOutput("t5_done_k1", 32'(frameDone), 32'h1);
        checkOutput("t5_in_ready_k1", 32'(pix.in_ready), 32'h0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_busy_k2", 32'(busy), 32'h0);
        checkOutput("t5_done_k2", 32'(frameDone), 32'h0);
        checkOutput("t5_in_ready_k2", 32'(pix.in_ready), 32'h0);

        // Abort in DRAIN with three stalled stages, abort beats frame_start
        applyStimulus(1'b1, 16'd3, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("t6_in_ready_k%0d", k), 32'(pix.in_ready), 32'(k <= 3));
        end
        applyStimulus(1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_valid_pre_abort", 32'(stageValid), 32'hE);
        checkOutput("t6_busy_pre_abort", 32'(busy), 32'h1);
        checkOutput("t6_stall", 32'(stallCycles), STALL_T6);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t6_valid_post", 32'(stageValid), 32'h0);
        checkOutput("t6_busy_post", 32'(busy), 32'h0);
        checkOutput("t6_done_post", 32'(frameDone), 32'h0);
        checkOutput("t6_in_ready_post", 32'(pix.in_ready), 32'h0);
        checkOutput("t6_stall_post", 32'(stallCycles), 32'h0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t6_done_post2", 32'(frameDone), 32'h0);
        applyStimulus(1'b1, 16'd2, 1'b0, 1'b1, 1'b1);
        gotDone = 1'b0;
        for (int k = 1; k <= 20 && !gotDone; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
            if (k == 1) checkOutput("t6_restart_busy", 32'(busy), 32'h1);
            gotDone = frameDone;
        end
        checkOutput("t6_restart_done", 32'(gotDone), 32'h1);
        checkOutput("t6_restart_count", 32'(outIdx), 32'd2);

        // Reset in the middle of a frame
        applyStimulus(1'b1, 16'd8, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        checkOutput("t7_valid", 32'(stageValid), 32'h0);
        checkOutput("t7_busy", 32'(busy), 32'h0);
        checkOutput("t7_in_ready", 32'(pix.in_ready), 32'h0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t7_done", 32'(frameDone), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
